// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Holds the FSM state encoding, parity-mode constants and the baud counter width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int PARITY_MODE_EVEN = 0;
    localparam int PARITY_MODE_ODD  = 1;

    // Bits needed to hold a count of 0 .. clks_per_bit-1.
    function automatic int baud_cnt_width(input int clks_per_bit);
        return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/uart_rx_baud.sv
// Baud tick generator: loadable down-counter producing a one-cycle sample tick.
// A load arms a half-period to reach mid-bit; each tick reloads a full period.
module uart_rx_baud
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int CW = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= HALF_M1;
        end else if (cnt_q == '0) begin
            cnt_q <= FULL_M1;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick = (cnt_q == '0) && !load;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with held data register, valid/read handshake and error flags.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 data_rd,
    output logic [DATA_BITS-1:0] data_i,
    output logic                 data_valid,
    output logic                 receive_ack,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 LED
);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_rx_param: parameter out of legal range");
    end

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    // Handshake: data_valid rises with receive_ack and stays high until data_rd is
    // seen while data_valid=1; a completing frame always wins over a same-cycle read.
    rx_state_t state_q, state_d;

    logic                 rxd_meta, rxd_s, rxd_prev;
    logic                 fall;
    logic                 load, tick, done;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 stop_err_q;
    logic                 frame_err_now;
    logic                 parity_err_now;

    uart_rx_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .load(load),
        .tick(tick)
    );

    assign fall = rxd_prev && !rxd_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && bit_cnt == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick && bit_cnt == LAST_STOP) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    // bit_cnt is shared by the data and stop phases; it restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift_q    <= '0;
            stop_err_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                bit_cnt <= '0;
            end else if (tick && (state_q == DATA || state_q == STOP)) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state_q == DATA && tick) begin
                shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
            end
            if (load) begin
                stop_err_q <= 1'b0;
            end else if (state_q == STOP && tick && !rxd_s) begin
                stop_err_q <= 1'b1;
            end
        end
    end

    assign frame_err_now = stop_err_q || !rxd_s;

`ifdef UART_RX_PARITY_EN
    logic par_err_q;
    logic exp_par;

    assign exp_par = (PARITY_ODD == PARITY_MODE_ODD) ? ~^shift_q : ^shift_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_q  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (load) begin
                par_err_q <= 1'b0;
            end else if (state_q == PARITY && tick) begin
                par_err_q <= rxd_s ^ exp_par;
            end
            if (done) begin
                parity_err <= par_err_q;
            end
        end
    end

    assign parity_err_now = par_err_q;
`else
    assign parity_err     = 1'b0;
    assign parity_err_now = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_i      <= '0;
            data_valid  <= 1'b0;
            receive_ack <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            LED         <= 1'b0;
        end else begin
            receive_ack <= done;
            if (done) begin
                data_i     <= shift_q;
                data_valid <= 1'b1;
                frame_err  <= frame_err_now;
                if (data_valid && !data_rd) begin
                    overrun <= 1'b1;
                end else if (data_rd) begin
                    overrun <= 1'b0;
                end
                if (!frame_err_now && !parity_err_now) begin
                    LED <= ~LED;
                end
            end else if (data_rd && data_valid) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: vector table, corner-case sequences and
// randomized frames checked against a frame-level reference model.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int C    = 16;
    localparam int D    = 8;
    localparam int S    = 1;
    localparam int PODD = 0;

    logic         clk = 1'b0;
    logic         rst;
    logic         rxd;
    logic         data_rd;
    logic [D-1:0] data_i;
    logic         data_valid;
    logic         receive_ack;
    logic         frame_err;
    logic         parity_err;
    logic         overrun;
    logic         LED;

    int n_vec   = 0;
    int n_miss  = 0;
    int ack_cnt = 0;

    uart_rx_param #(
        .CLKS_PER_BIT(C),
        .DATA_BITS   (D),
        .STOP_BITS   (S),
        .PARITY_ODD  (PODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .data_rd    (data_rd),
        .data_i     (data_i),
        .data_valid (data_valid),
        .receive_ack(receive_ack),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .LED        (LED)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (receive_ack) ack_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (C) @(negedge clk);
    endtask

    function automatic logic good_parity(input logic [D-1:0] d);
        return (($countones(d) % 2) == 1) ^ (PODD != 0);
    endfunction

    task automatic send_frame(input logic [D-1:0] d, input logic stop_val, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < D; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(good_parity(d) ^ par_flip);
`else
        if (par_flip) rxd = 1'b1;
`endif
        for (int i = 0; i < S; i++) send_bit(stop_val);
    endtask

    task automatic pulse_rd();
        data_rd = 1'b1;
        @(negedge clk);
        data_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input logic [D-1:0] e_data, input logic e_valid,
                            input logic e_ferr, input logic e_perr, input logic e_ovr,
                            input logic e_led);
        chk({tag, ".data"}, data_i, e_data);
        chk({tag, ".valid"}, data_valid, e_valid);
        chk({tag, ".frame_err"}, frame_err, e_ferr);
        chk({tag, ".parity_err"}, parity_err, e_perr);
        chk({tag, ".overrun"}, overrun, e_ovr);
        chk({tag, ".led"}, LED, e_led);
    endtask

    typedef struct {
        logic [D-1:0] data;
        logic         stop;
        logic         rd;
        logic [D-1:0] e_data;
        logic         e_valid;
        logic         e_ferr;
        logic         e_ovr;
        logic         e_led;
    } vec_t;

    vec_t vt[6];

    // scoreboard: model state and expected-word queue
    logic [D-1:0] exp_q[$];
    logic         m_valid, m_ovr, m_led, m_ferr, m_perr;
    logic [D-1:0] m_data;

    initial begin
        int a0;
        logic [D-1:0] s_data;
        logic s_valid, s_ferr, s_ovr, s_led;

        vt[0] = '{8'h39, 1'b1, 1'b0, 8'h39, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[2] = '{8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[3] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        rxd = 1'b1;
        data_rd = 1'b0;
        repeat (3) @(negedge clk);
        chk_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.ack", receive_ack, 1'b0);
        chk("reset.state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // table-driven frames
        for (int i = 0; i < 6; i++) begin
            a0 = ack_cnt;
            if (vt[i].rd) pulse_rd();
            send_frame(vt[i].data, vt[i].stop, 1'b0);
            idle(8);
            chk_outs($sformatf("vec%0d", i), vt[i].e_data, vt[i].e_valid, vt[i].e_ferr, 1'b0,
                     vt[i].e_ovr, vt[i].e_led);
            chk($sformatf("vec%0d.acks", i), ack_cnt - a0, 1);
        end

        // glitch shorter than half a bit
        a0 = ack_cnt;
        s_data = data_i; s_valid = data_valid; s_ferr = frame_err; s_ovr = overrun; s_led = LED;
        rxd = 1'b0;
        repeat (6) @(negedge clk);
        idle(30);
        chk("glitch.acks", ack_cnt - a0, 0);
        chk("glitch.state", 32'(dut.state_q), 32'(IDLE));
        chk_outs("glitch", s_data, s_valid, s_ferr, 1'b0, s_ovr, s_led);

        // back-to-back frames without read
        pulse_rd();
        a0 = ack_cnt;
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h66, 1'b1, 1'b0);
        idle(4);
        chk("b2b.acks", ack_cnt - a0, 2);
        chk_outs("b2b", 8'h66, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        pulse_rd();
        chk("b2b_rd.valid", data_valid, 1'b0);
        chk("b2b_rd.overrun", overrun, 1'b0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        idle(4);
        chk_outs("par_bad", 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        pulse_rd();
        send_frame(8'h07, 1'b1, 1'b0);
        idle(4);
        chk_outs("par_good", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // reset during the fourth data bit
        pulse_rd();
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(4);
        a0 = ack_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rxd = 1'b0;
        repeat (C / 2) @(negedge clk);
        rst = 1'b1;
        rxd = 1'b1;
        #1;
        chk_outs("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst.state", 32'(dut.state_q), 32'(IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(10);
        chk("midrst.noack", ack_cnt - a0, 0);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(4);
        chk("after_rst.acks", ack_cnt - a0, 1);
        chk_outs("after_rst", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // randomized frames against the frame-level model
        do_reset();
        m_valid = 1'b0; m_ovr = 1'b0; m_led = 1'b0; m_data = '0;
        for (int k = 0; k < 40; k++) begin
            logic [D-1:0] d;
            logic stop_ok, flip, rd;
            d = D'($urandom_range(0, (1 << D) - 1));
            stop_ok = ($urandom_range(0, 9) != 0);
`ifdef UART_RX_PARITY_EN
            flip = ($urandom_range(0, 3) == 0);
`else
            flip = 1'b0;
`endif
            rd = 1'($urandom_range(0, 1));
            if (rd) begin
                pulse_rd();
                if (m_valid) begin
                    m_valid = 1'b0;
                    m_ovr = 1'b0;
                end
            end
            a0 = ack_cnt;
            exp_q.push_back(d);
            send_frame(d, stop_ok, flip);
            idle($urandom_range(2, 20));
            m_ferr = !stop_ok;
            m_perr = flip;
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_data = exp_q.pop_front();
            if (!m_ferr && !m_perr) m_led = ~m_led;
            chk_outs($sformatf("rnd%0d", k), m_data, m_valid, m_ferr, m_perr, m_ovr, m_led);
            chk($sformatf("rnd%0d.acks", k), ack_cnt - a0, 1);
        end

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
